ternary_serial_encoder: RTL and testbench

Binary-to-ternary serializer. Accepts one unsigned binary word over a valid/ready handshake and emits its balanced-free (standard, unsigned) base-3 digits one trit per handshake, least-significant trit first. Uses the team's 2-bit trit encoding, so its output feeds the ternary min/max/any/consensus datapath directly. It is the producer side of the trit stream those gates consume.

---
 rtl/ternary_serial_encoder.sv | 85 ++++++++
 tb/tb_ternary_serial_encoder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_serial_encoder.sv
// Binary-to-ternary serializer, LSB trit first, 2-bit trit encoding.
// Optional TERNARY_ENC_SKIP_LZ_EN: stop after the top non-zero trit.
module ternary_serial_encoder #(
  parameter int WIDTH  = 8,
  parameter int NTRITS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_trit,
  output logic             out_last
);

  localparam int CW = (NTRITS > 1) ? $clog2(NTRITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(NTRITS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_div;
  logic [1:0]       q_mod;
  logic [CW-1:0]    cnt;
  logic             last_c;
  logic             send;

  // Constant divide-by-3 and remainder of the current quotient.
  always_comb begin
    q_div = q / WIDTH'(3);
    q_mod = 2'(q - q_div * WIDTH'(3));
  end

  // Final-trit detection; early stop once the next quotient is zero.
  always_comb begin
`ifdef TERNARY_ENC_SKIP_LZ_EN
    last_c = (cnt == CNT_MAX) || (q_div == '0);
`else
    last_c = (cnt == CNT_MAX);
`endif
  end

  assign send      = (state == SEND);
  assign in_ready  = (state == IDLE);
  assign out_valid = send;
  assign out_trit  = send ? q_mod : 2'b00;
  assign out_last  = send & last_c;

  // Accept a word in IDLE, shift out one trit per output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            q     <= in_data;
            cnt   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (last_c) begin
              state <= IDLE;
            end else begin
              q   <= q_div;
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_serial_encoder.sv
// Self-checking bench for ternary_serial_encoder.
// Randomized words checked against an arithmetic base-3 model.
module tb_ternary_serial_encoder;

  localparam int WIDTH  = 8;
  localparam int NTRITS = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_trit;
  logic             out_last;

  int checks = 0;
  int failures = 0;

  logic [1:0] got_t[$];
  logic       got_l[$];
  logic [1:0] exp_t[$];
  logic       exp_l[$];
  logic       timeout;
  logic       first_valid;

  ternary_serial_encoder #(.WIDTH(WIDTH), .NTRITS(NTRITS)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_trit(out_trit),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: repeated division by 3, LSB digit first.
  task automatic model(input int v);
    int x;
    bit last;
    exp_t.delete();
    exp_l.delete();
    x = v;
    for (int i = 0; i < NTRITS; i++) begin
      exp_t.push_back(2'(x % 3));
      x = x / 3;
      last = (i == NTRITS - 1);
`ifdef TERNARY_ENC_SKIP_LZ_EN
      if (x == 0) last = 1'b1;
`endif
      exp_l.push_back(last);
      if (last) break;
    end
  endtask

  task automatic accept(input logic [WIDTH-1:0] v);
    int guard;
    timeout = 1'b0;
    in_data = v;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) timeout = 1'b1;
    tick();
    first_valid = out_valid;
    in_valid = 1'b0;
    in_data = WIDTH'($urandom);
  endtask

  task automatic collect(input int stall_pct);
    int guard;
    bit done;
    guard = 0;
    done = 0;
    while (!done && guard < 300) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      if (out_valid && out_ready) begin
        got_t.push_back(out_trit);
        got_l.push_back(out_last);
        if (out_last) done = 1;
      end
      tick();
      guard++;
    end
    if (!done) timeout = 1'b1;
    out_ready = 1'b0;
  endtask

  task automatic run_word(input logic [WIDTH-1:0] v, input int stall_pct);
    got_t.delete();
    got_l.delete();
    accept(v);
    collect(stall_pct);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_trit !== 2'b00 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset: got rdy=%b vld=%b trit=%b last=%b exp 1 0 00 0",
               in_ready, out_valid, out_trit, out_last);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_word_255();
    logic [1:0] lit[6];
    lit = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    run_word(8'd255, 0);
    checks++;
    if (timeout || first_valid !== 1'b1 || got_t.size() != 6) begin
      failures++;
      $display("FAIL w255_len: got n=%0d to=%b fv=%b exp n=6 to=0 fv=1",
               got_t.size(), timeout, first_valid);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_t[i] !== lit[i] || got_l[i] !== (i == 5)) begin
          failures++;
          $display("FAIL w255_trit%0d: got %b/%b exp %b/%b",
                   i, got_t[i], got_l[i], lit[i], (i == 5));
        end
      end
    end
  endtask

  task automatic test_small_words();
    int vals[2];
    vals = '{5, 0};
    foreach (vals[k]) begin
      model(vals[k]);
      run_word(WIDTH'(vals[k]), 0);
      checks++;
      if (timeout || got_t.size() != exp_t.size()) begin
        failures++;
        $display("FAIL small%0d_len: got n=%0d to=%b exp n=%0d",
                 vals[k], got_t.size(), timeout, exp_t.size());
      end else begin
        foreach (exp_t[i]) begin
          checks++;
          if (got_t[i] !== exp_t[i] || got_l[i] !== exp_l[i]) begin
            failures++;
            $display("FAIL small%0d_trit%0d: got %b/%b exp %b/%b",
                     vals[k], i, got_t[i], got_l[i], exp_t[i], exp_l[i]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    got_t.delete();
    got_l.delete();
    model(255);
    accept(8'd255);
    out_ready = 1'b1;
    got_t.push_back(out_trit);
    got_l.push_back(out_last);
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd77;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_trit !== 2'b01 ||
          out_last !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall%0d: got v=%b t=%b l=%b r=%b exp 1 01 0 0",
                 c, out_valid, out_trit, out_last, in_ready);
      end
      tick();
    end
    collect(0);
    in_valid = 1'b0;
    checks++;
    if (timeout || got_t.size() != exp_t.size()) begin
      failures++;
      $display("FAIL bp_len: got n=%0d to=%b exp n=%0d",
               got_t.size(), timeout, exp_t.size());
    end else begin
      foreach (exp_t[i]) begin
        checks++;
        if (got_t[i] !== exp_t[i] || got_l[i] !== exp_l[i]) begin
          failures++;
          $display("FAIL bp_trit%0d: got %b/%b exp %b/%b",
                   i, got_t[i], got_l[i], exp_t[i], exp_l[i]);
        end
      end
    end
    // The stalled in_valid must not have started a word.
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_noaccept: got v=%b r=%b exp 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    accept(8'd255);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_trit !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid: got v=%b r=%b t=%b exp 0 1 00",
               out_valid, in_ready, out_trit);
    end
    model(5);
    run_word(8'd5, 0);
    checks++;
    if (timeout || got_t.size() != exp_t.size()) begin
      failures++;
      $display("FAIL rst_w5_len: got n=%0d to=%b exp n=%0d",
               got_t.size(), timeout, exp_t.size());
    end else begin
      foreach (exp_t[i]) begin
        checks++;
        if (got_t[i] !== exp_t[i] || got_l[i] !== exp_l[i]) begin
          failures++;
          $display("FAIL rst_w5_trit%0d: got %b/%b exp %b/%b",
                   i, got_t[i], got_l[i], exp_t[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n7;
    int gap;
    logic idle_ok;
    got_t.delete();
    got_l.delete();
    model(7);
    n7 = exp_t.size();
    accept(8'd7);
    in_valid = 1'b1;
    in_data = 8'd8;
    out_ready = 1'b1;
    gap = 0;
    while (!in_ready && gap < 50) begin
      if (out_valid) begin
        got_t.push_back(out_trit);
        got_l.push_back(out_last);
      end
      tick();
      gap++;
    end
    idle_ok = (out_valid === 1'b0);
    checks++;
    if (gap != n7 || !idle_ok) begin
      failures++;
      $display("FAIL b2b_gap: got gap=%0d idle=%b exp gap=%0d idle=1",
               gap, idle_ok, n7);
    end
    foreach (exp_t[i]) begin
      checks++;
      if (i >= got_t.size() || got_t[i] !== exp_t[i] ||
          got_l[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL b2b_w7_trit%0d: exp %b/%b", i, exp_t[i], exp_l[i]);
      end
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_w8_start: got v=%b exp 1", out_valid);
    end
    got_t.delete();
    got_l.delete();
    model(8);
    timeout = 1'b0;
    collect(0);
    checks++;
    if (timeout || got_t.size() != exp_t.size()) begin
      failures++;
      $display("FAIL b2b_w8_len: got n=%0d to=%b exp n=%0d",
               got_t.size(), timeout, exp_t.size());
    end else begin
      foreach (exp_t[i]) begin
        checks++;
        if (got_t[i] !== exp_t[i] || got_l[i] !== exp_l[i]) begin
          failures++;
          $display("FAIL b2b_w8_trit%0d: got %b/%b exp %b/%b",
                   i, got_t[i], got_l[i], exp_t[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int v;
    for (int w = 0; w < 40; w++) begin
      v = $urandom_range(255);
      model(v);
      run_word(WIDTH'(v), 35);
      checks++;
      if (timeout || got_t.size() != exp_t.size()) begin
        failures++;
        $display("FAIL rnd%0d_len v=%0d: got n=%0d to=%b exp n=%0d",
                 w, v, got_t.size(), timeout, exp_t.size());
      end else begin
        foreach (exp_t[i]) begin
          checks++;
          if (got_t[i] !== exp_t[i] || got_l[i] !== exp_l[i]) begin
            failures++;
            $display("FAIL rnd%0d_trit%0d v=%0d: got %b/%b exp %b/%b",
                     w, i, v, got_t[i], got_l[i], exp_t[i], exp_l[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_255();
    test_small_words();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
